// File: rtl/leglite_dmem_io_if.sv
// leglite_dmem_io_if: core data-memory bus plus the buffered output and latched input ports.
interface leglite_dmem_io_if;
    logic [15:0] daddr;
    logic        dread;
    logic        dwrite;
    logic [15:0] dwdata;
    logic [15:0] ddata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic        in_strobe;
    modport master (
        output daddr, dread, dwrite, dwdata, out_ready, in_data, in_strobe,
        input  ddata, out_data, out_valid
    );
    modport slave (
        input  daddr, dread, dwrite, dwdata, out_ready, in_data, in_strobe,
        output ddata, out_data, out_valid
    );
endinterface

// File: rtl/leglite_dmem_io.sv
// leglite_dmem_io: word RAM plus MMIO page (output FIFO, latched input, free-running timer) for the LEGLite core.
module leglite_dmem_io #(
    parameter int RAM_AW  = 7,
    parameter int FIFO_AW = 2
) (
    input logic              clk,
    input logic              rst_n,
    leglite_dmem_io_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    logic [15:0]        ram [2 ** RAM_AW];
    logic [15:0]        fifo [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [15:0]        in_reg, timer, status;
    logic               in_valid, in_ovr, out_ovf;
    logic               ram_sel, full, empty, push_req, push, pop, ovf_evt, in_rd, st_rd, ovr_evt, tmr_wr;
    logic [RAM_AW-1:0]  idx;
    assign idx      = bus.daddr[RAM_AW-1:0];
    assign ram_sel  = bus.daddr < 16'hFFF0;
    assign full     = count == (FIFO_AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign push_req = bus.dwrite && bus.daddr == 16'hFFF0;
    assign pop      = !empty && bus.out_ready;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push     = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;
    assign in_rd    = bus.dread && bus.daddr == 16'hFFF2;
    assign st_rd    = bus.dread && bus.daddr == 16'hFFF1;
    assign ovr_evt  = bus.in_strobe && in_valid && !in_rd;
    assign tmr_wr   = bus.dwrite && bus.daddr == 16'hFFF3;
    assign status   = {11'b0, in_ovr, out_ovf, in_valid, full, empty};
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 16'h0 : fifo[rd_ptr];
    always_comb begin
        bus.ddata = !bus.dread           ? 16'h0 :
                    ram_sel              ? ram[idx] :
                    bus.daddr == 16'hFFF1 ? status :
                    bus.daddr == 16'hFFF2 ? in_reg :
                    bus.daddr == 16'hFFF3 ? timer : 16'h0;
    end
    always_ff @(posedge clk) begin
        if (bus.dwrite && ram_sel) ram[idx] <= bus.dwdata;
        if (push) fifo[wr_ptr] <= bus.dwdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_reg   <= '0;
            in_valid <= 1'b0;
            in_ovr   <= 1'b0;
            out_ovf  <= 1'b0;
            timer    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            count    <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            if (bus.in_strobe) in_reg <= bus.in_data;
            in_valid <= bus.in_strobe ? 1'b1 : in_rd ? 1'b0 : in_valid;
            in_ovr   <= ovr_evt ? 1'b1 : st_rd ? 1'b0 : in_ovr;
            out_ovf  <= ovf_evt ? 1'b1 : st_rd ? 1'b0 : out_ovf;
            timer    <= tmr_wr ? bus.dwdata : timer + 16'd1;
        end
    end
endmodule

// File: tb/tb_leglite_dmem_io.sv
// tb_leglite_dmem_io: directed vectors with hand-computed expectations for leglite_dmem_io.
module tb_leglite_dmem_io;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    leglite_dmem_io_if bus();
    leglite_dmem_io dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        bus.daddr  = a;
        bus.dread  = r;
        bus.dwrite = w;
        bus.dwdata = d;
    endtask
    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        drive(a, 1'b1, 1'b0, 16'h0);
        #1 check(tag, bus.ddata, exp);
    endtask
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(a, 1'b0, 1'b1, d);
        tick();
    endtask
    task automatic idle;
        drive(16'h0, 1'b0, 1'b0, 16'h0);
    endtask
    initial begin
        idle();
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_strobe = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {15'b0, bus.out_valid}, 16'h0);
        check("rst_out_data", bus.out_data, 16'h0);
        drive(16'hFFF1, 1'b0, 1'b0, 16'h0);
        #1 check("ddata_no_read", bus.ddata, 16'h0);
        rd("rst_status", 16'hFFF1, 16'h0001);
        rd("rst_timer", 16'hFFF3, 16'h0000);
        idle();
        rst_n = 1'b1;
        tick();
        wr(16'h0005, 16'h1234);
        rd("ram_read", 16'h0005, 16'h1234);
        tick();
        rd("ram_alias", 16'h0085, 16'h1234);
        tick();
        drive(16'h0005, 1'b1, 1'b1, 16'h5678);
        #1 check("ram_rw_old", bus.ddata, 16'h1234);
        tick();
        rd("ram_rw_new", 16'h0005, 16'h5678);
        tick();
        wr(16'hFFF5, 16'hBEEF);
        rd("reserved_rd", 16'hFFF5, 16'h0000);
        rd("outdata_rd", 16'hFFF0, 16'h0000);
        tick();
        for (int i = 1; i <= 5; i++) wr(16'hFFF0, 16'h00A0 + 16'(i));
        rd("fifo_full_ovf", 16'hFFF1, 16'h000A);
        check("fifo_head", bus.out_data, 16'h00A1);
        check("fifo_valid", {15'b0, bus.out_valid}, 16'h1);
        tick();
        rd("ovf_cleared", 16'hFFF1, 16'h0002);
        tick();
        idle();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1 check($sformatf("drain_%0d", i), bus.out_data, 16'h00A0 + 16'(i));
            tick();
        end
        check("drained_valid", {15'b0, bus.out_valid}, 16'h0);
        check("drained_data", bus.out_data, 16'h0);
        rd("drained_status", 16'hFFF1, 16'h0001);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(16'hFFF0, 16'h00C0 + 16'(i));
        bus.out_ready = 1'b1;
        wr(16'hFFF0, 16'h00B0);
        rd("push_pop_full", 16'hFFF1, 16'h0002);
        check("pp_head", bus.out_data, 16'h00C2);
        tick();
        idle();
        #1 check("pp_c3", bus.out_data, 16'h00C3);
        tick();
        check("pp_c4", bus.out_data, 16'h00C4);
        tick();
        check("pp_b0", bus.out_data, 16'h00B0);
        tick();
        check("pp_empty", {15'b0, bus.out_valid}, 16'h0);
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0055;
        bus.in_strobe = 1'b1;
        tick();
        bus.in_strobe = 1'b0;
        rd("in_valid_set", 16'hFFF1, 16'h0005);
        tick();
        rd("in_data_rd", 16'hFFF2, 16'h0055);
        tick();
        rd("in_valid_clr", 16'hFFF1, 16'h0001);
        tick();
        idle();
        bus.in_data   = 16'h0011;
        bus.in_strobe = 1'b1;
        tick();
        bus.in_data   = 16'h0022;
        tick();
        bus.in_strobe = 1'b0;
        rd("in_ovr_set", 16'hFFF1, 16'h0015);
        tick();
        rd("in_last_kept", 16'hFFF2, 16'h0022);
        tick();
        rd("in_ovr_clr", 16'hFFF1, 16'h0001);
        tick();
        idle();
        bus.in_data   = 16'h0033;
        bus.in_strobe = 1'b1;
        tick();
        bus.in_data   = 16'h0044;
        rd("in_rd_strobe", 16'hFFF2, 16'h0033);
        tick();
        bus.in_strobe = 1'b0;
        rd("in_new_wins", 16'hFFF1, 16'h0005);
        tick();
        rd("in_new_data", 16'hFFF2, 16'h0044);
        tick();
        wr(16'hFFF3, 16'hFFFE);
        rd("timer_load", 16'hFFF3, 16'hFFFE);
        tick();
        rd("timer_inc", 16'hFFF3, 16'hFFFF);
        tick();
        rd("timer_wrap", 16'hFFF3, 16'h0000);
        tick();
        for (int i = 1; i <= 4; i++) wr(16'hFFF0, 16'h00D0 + 16'(i));
        idle();
        bus.out_ready = 1'b1;
        tick();
        check("mid_drain_head", bus.out_data, 16'h00D2);
        #2 rst_n = 1'b0;
        #1 check("arst_valid", {15'b0, bus.out_valid}, 16'h0);
        check("arst_data", bus.out_data, 16'h0);
        rd("arst_timer", 16'hFFF3, 16'h0000);
        rd("arst_status", 16'hFFF1, 16'h0001);
        rd("arst_ram_kept", 16'h0005, 16'h5678);
        idle();
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(16'hFFF0, 16'h00E1);
        idle();
        #1 check("post_rst_push", bus.out_data, 16'h00E1);
        check("post_rst_valid", {15'b0, bus.out_valid}, 16'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
